// File: rtl/monolith_perm_ctrl.sv
// monolith_perm_ctrl
//
// Runs one full Monolith permutation on a single external monolith_round
// instance. It takes a state vector over a valid/ready handshake and runs the
// pre-round (round 0), then NUM_ROUNDS full rounds. For each round it
// restarts the round block, drives its inputs, and captures its result. It
// then presents the permuted state over a valid/ready handshake.
// This block does no field arithmetic.
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   in_valid/in_ready input handshake; in_ready is high only while idle
//   in_state          permutation input (STATE_SIZE words of WORD_WIDTH)
//   out_valid/out_ready output handshake; out_state mirrors the working state
//   round_idx         current round (0 = pre-round), addresses the constant ROM
//   rc                round constants for round_idx, combinational from the ROM
//   round_reset       reset/start to the round block, low only while waiting
//   round_pre_round   pre-round flag to the round block
//   round_state_in    state to the round block
//   round_constants   constants to the round block (zero in the final round)
//   round_state_out   round result
//   round_valid       round result valid, sticky until the next round_reset
//   error             sticky watchdog flag
//
// Configuration
//   MONOLITH_CTRL_TIMEOUT_EN  when defined, a per-round watchdog aborts a round
//                             after TIMEOUT_CYCLES waiting cycles, sets error
//                             and returns to IDLE. When undefined, error is
//                             tied low and TIMEOUT_CYCLES is unused.

module monolith_perm_ctrl #(
  parameter int unsigned WORD_WIDTH     = 31,
  parameter int unsigned STATE_SIZE     = 16,
  parameter int unsigned NUM_ROUNDS     = 6,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  localparam int unsigned IDX_W         = $clog2(NUM_ROUNDS + 1)
) (
  input  logic                                 clk,
  input  logic                                 reset,

  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] in_state,

  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] out_state,

  output logic [IDX_W-1:0]                     round_idx,
  input  logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] rc,

  output logic                                 round_reset,
  output logic                                 round_pre_round,
  output logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] round_state_in,
  output logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] round_constants,
  input  logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] round_state_out,
  input  logic                                 round_valid,

  output logic                                 error
);

  localparam logic [IDX_W-1:0] LAST_RND = IDX_W'(NUM_ROUNDS);

  typedef logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] state_vec_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] rnd_q, rnd_d;
  state_vec_t       state_reg_q, state_reg_d;

  logic in_ready_d;
  logic out_valid_d;
  logic round_reset_d;
  logic round_pre_round_d;

`ifdef MONOLITH_CTRL_TIMEOUT_EN
  localparam int unsigned    WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            error_q, error_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // Next-state, datapath capture and registered-output next values.
  always_comb begin
    state_d     = state_q;
    rnd_d       = rnd_q;
    state_reg_d = state_reg_q;
`ifdef MONOLITH_CTRL_TIMEOUT_EN
    wd_cnt_d    = wd_cnt_q;
    error_d     = error_q;
`endif

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          state_reg_d = in_state;
          rnd_d       = '0;
          state_d     = LAUNCH;
`ifdef MONOLITH_CTRL_TIMEOUT_EN
          error_d     = 1'b0;
`endif
        end
      end

      // round_valid may still be high from the previous round here, so it is
      // deliberately not looked at.
      LAUNCH: begin
        state_d = WAIT;
`ifdef MONOLITH_CTRL_TIMEOUT_EN
        wd_cnt_d = '0;
`endif
      end

      WAIT: begin
        if (round_valid) begin
          state_reg_d = round_state_out;
          if (rnd_q == LAST_RND) begin
            state_d = DONE;
          end else begin
            rnd_d   = rnd_q + IDX_W'(1);
            state_d = LAUNCH;
          end
        end
`ifdef MONOLITH_CTRL_TIMEOUT_EN
        else if (wd_cnt_q == WD_LAST) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else begin
          wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
`endif
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Handshake and round-control outputs follow the state being entered.
    in_ready_d        = (state_d == IDLE);
    out_valid_d       = (state_d == DONE);
    round_reset_d     = (state_d != WAIT);
    round_pre_round_d = ((state_d == LAUNCH) || (state_d == WAIT)) && (rnd_d == '0);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      rnd_q           <= '0;
      state_reg_q     <= '0;
      in_ready        <= 1'b0;
      out_valid       <= 1'b0;
      round_reset     <= 1'b1;
      round_pre_round <= 1'b0;
    end else begin
      state_q         <= state_d;
      rnd_q           <= rnd_d;
      state_reg_q     <= state_reg_d;
      in_ready        <= in_ready_d;
      out_valid       <= out_valid_d;
      round_reset     <= round_reset_d;
      round_pre_round <= round_pre_round_d;
    end
  end

`ifdef MONOLITH_CTRL_TIMEOUT_EN
  // Per-round watchdog and sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt_q <= '0;
      error_q  <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      error_q  <= error_d;
    end
  end

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  // state_reg only changes on accept or when a round finishes. It therefore
  // stays constant across LAUNCH and WAIT and can feed the round block directly.
  assign round_state_in = state_reg_q;
  assign out_state      = state_reg_q;
  assign round_idx      = rnd_q;

  // The ROM is addressed by round_idx, so rc already tracks the current round
  // and is stable through LAUNCH and WAIT. The final round uses no constants.
  assign round_constants = (rnd_q == LAST_RND) ? '0 : rc;

endmodule

// File: tb/tb_monolith_perm_ctrl.sv
// Directed testbench for monolith_perm_ctrl. A behavioural round model adds
// round_idx to every word and raises round_valid in the W-th waiting cycle.
// The constant ROM returns round_idx+100 in every word.
module tb_monolith_perm_ctrl;

  localparam int unsigned WW = 31;
  localparam int unsigned SS = 16;
  localparam int unsigned NR = 6;
  localparam int unsigned TO = 8;
  localparam int unsigned IW = $clog2(NR + 1);
  localparam int unsigned VW = WW * SS;

  typedef logic [SS-1:0][WW-1:0] vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid;
  logic          in_ready;
  vec_t          in_state;
  logic          out_valid;
  logic          out_ready;
  vec_t          out_state;
  logic [IW-1:0] round_idx;
  vec_t          rc;
  logic          round_reset;
  logic          round_pre_round;
  vec_t          round_state_in;
  vec_t          round_constants;
  vec_t          round_state_out;
  logic          round_valid;
  logic          error;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  monolith_perm_ctrl #(
    .WORD_WIDTH    (WW),
    .STATE_SIZE    (SS),
    .NUM_ROUNDS    (NR),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_state       (in_state),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_state      (out_state),
    .round_idx      (round_idx),
    .rc             (rc),
    .round_reset    (round_reset),
    .round_pre_round(round_pre_round),
    .round_state_in (round_state_in),
    .round_constants(round_constants),
    .round_state_out(round_state_out),
    .round_valid    (round_valid),
    .error          (error)
  );

  function automatic vec_t fill(input logic [WW-1:0] w);
    vec_t r;
    for (int i = 0; i < SS; i++) r[i] = w;
    return r;
  endfunction

  function automatic vec_t add_k(input vec_t v, input int k);
    vec_t r;
    for (int i = 0; i < SS; i++) r[i] = v[i] + WW'(k);
    return r;
  endfunction

  function automatic vec_t exp_rc(input int k);
    if (k < int'(NR)) return fill(WW'(k + 100));
    return '0;
  endfunction

  // Constant ROM.
  assign rc = fill(WW'(int'(round_idx) + 100));

  // Behavioural round block: samples inputs on every edge where round_reset
  // is high, and raises a sticky valid in the rm_w-th cycle after release.
  int            rm_w;
  int            rm_cnt;
  vec_t          rm_in;
  logic [IW-1:0] rm_idx;

  always @(posedge clk) begin
    if (round_reset) begin
      rm_cnt <= 0;
      rm_in  <= round_state_in;
      rm_idx <= round_idx;
    end else begin
      rm_cnt <= rm_cnt + 1;
    end
  end

  assign round_valid     = (rm_cnt >= rm_w - 1);
  assign round_state_out = add_k(rm_in, int'(rm_idx));

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One permutation with round latency w. The output handshake is held off
  // for bp cycles. ef is the hand-computed final state.
  task automatic run_perm(input vec_t st, input int w, input int bp, input vec_t ef);
    vec_t exp;
    vec_t held;
    int   cyc;
    int   launches;
    bit   done;
    rm_w = w;
    @(negedge clk);
    check("idle_in_ready", VW'(in_ready), VW'(1'b1));
    in_state = st;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    exp = st;
    cyc = 0;
    launches = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      cyc++;
      if (cyc > 400) begin
        check("out_valid_timeout", VW'(out_valid), VW'(1'b1));
        done = 1'b1;
      end else if (out_valid) begin
        done = 1'b1;
      end else if (round_reset) begin
        if (launches > 0) exp = add_k(exp, launches - 1);
        check("launch_idx", VW'(round_idx), VW'(launches));
        check("launch_pre", VW'(round_pre_round), VW'(launches == 0));
        check("launch_rc", VW'(round_constants), VW'(exp_rc(launches)));
        check("launch_state", VW'(round_state_in), VW'(exp));
        launches++;
      end else begin
        check("wait_pre", VW'(round_pre_round), VW'(launches == 1));
        check("wait_rc", VW'(round_constants), VW'(exp_rc(launches - 1)));
        check("wait_state", VW'(round_state_in), VW'(exp));
      end
      if (!done) check("busy_in_ready", VW'(in_ready), VW'(1'b0));
    end
    exp = add_k(exp, int'(NR));
    check("latency", VW'(cyc - 1), VW'((int'(NR) + 1) * (1 + w)));
    check("launch_count", VW'(launches), VW'(int'(NR) + 1));
    check("out_state_model", VW'(out_state), VW'(exp));
    check("out_state_kat", VW'(out_state), VW'(ef));
    check("done_error", VW'(error), VW'(1'b0));
    held = out_state;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check("bp_out_valid", VW'(out_valid), VW'(1'b1));
      check("bp_out_state", VW'(out_state), VW'(held));
      check("bp_in_ready", VW'(in_ready), VW'(1'b0));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("post_out_valid", VW'(out_valid), VW'(1'b0));
    check("post_in_ready", VW'(in_ready), VW'(1'b1));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    vec_t v;
    vec_t e;
    int   cyc;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_state  = '0;
    rm_w      = 4;

    // Asynchronous reset values.
    #1 reset = 1'b1;
    #1;
    check("rst_in_ready", VW'(in_ready), VW'(1'b0));
    check("rst_out_valid", VW'(out_valid), VW'(1'b0));
    check("rst_round_reset", VW'(round_reset), VW'(1'b1));
    check("rst_pre_round", VW'(round_pre_round), VW'(1'b0));
    check("rst_round_idx", VW'(round_idx), VW'(0));
    check("rst_out_state", VW'(out_state), VW'(0));
    check("rst_error", VW'(error), VW'(1'b0));
    repeat (2) @(negedge clk);
    check("rst_held_in_ready", VW'(in_ready), VW'(1'b0));
    reset = 1'b0;
    #1 check("rel_in_ready", VW'(in_ready), VW'(1'b0));
    @(negedge clk);
    check("rel_in_ready_next", VW'(in_ready), VW'(1'b1));

    // Zeros, W=4: every word 0+1+...+6 = 21.
    run_perm(fill('0), 4, 0, fill(WW'(21)));

    // Words 0..15, W=1, 10 cycles of output backpressure.
    for (int i = 0; i < int'(SS); i++) begin
      v[i] = WW'(i);
      e[i] = WW'(i + 21);
    end
    run_perm(v, 1, 10, e);

    // Word wrap inside the round model: 0x7ffffff0 + 21 = 0x5 (mod 2^31).
    run_perm(fill(WW'(32'h7fff_fff0)), 2, 0, fill(WW'(5)));

    // Reset during round 3 WAIT abandons the permutation.
    rm_w = 4;
    @(negedge clk);
    in_state = fill(WW'(5));
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    cyc = 0;
    while (!((round_idx == IW'(3)) && !round_reset) && (cyc < 200)) begin
      @(negedge clk);
      cyc++;
    end
    check("mid_reached_r3", VW'(round_idx), VW'(3));
    check("mid_in_wait", VW'(round_reset), VW'(1'b0));
    #2 reset = 1'b1;
    #1;
    check("mid_out_valid", VW'(out_valid), VW'(1'b0));
    check("mid_round_reset", VW'(round_reset), VW'(1'b1));
    check("mid_pre_round", VW'(round_pre_round), VW'(1'b0));
    check("mid_round_idx", VW'(round_idx), VW'(0));
    check("mid_in_ready", VW'(in_ready), VW'(1'b0));
    check("mid_out_state", VW'(out_state), VW'(0));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rel_in_ready", VW'(in_ready), VW'(1'b1));
    check("mid_rel_out_valid", VW'(out_valid), VW'(1'b0));
    run_perm(fill(WW'(7)), 3, 0, fill(WW'(28)));

`ifdef MONOLITH_CTRL_TIMEOUT_EN
    // Round block never answers: LAUNCH + 8 WAIT cycles, then IDLE with error.
    begin
      bit saw_ov;
      rm_w = 1000;
      saw_ov = 1'b0;
      @(negedge clk);
      in_state = fill(WW'(9));
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      cyc = 0;
      while (!in_ready && (cyc < 100)) begin
        @(negedge clk);
        cyc++;
        if (out_valid) saw_ov = 1'b1;
        if (!in_ready) check("wd_error_low", VW'(error), VW'(1'b0));
      end
      check("wd_cycles", VW'(cyc), VW'(10));
      check("wd_error", VW'(error), VW'(1'b1));
      check("wd_no_out_valid", VW'(saw_ov), VW'(1'b0));
      check("wd_round_reset", VW'(round_reset), VW'(1'b1));
    end
    run_perm(fill(WW'(1)), 4, 0, fill(WW'(22)));
`else
    check("error_tied_low", VW'(error), VW'(1'b0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
